// File: rtl/sv_alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: controller state encoding,
// ALU field widths and the bit layout of one request slice.
// A request slice is {op, movi, a, b, mem, imm} with imm at bit 0.
package sv_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned ALU_MOVI_W = 2;
  // Wide enough for up to 8 ports; also the width of the err_port output.
  localparam int unsigned PORT_IDX_W = 3;

  localparam int unsigned IMM_LSB = 0;

  function automatic int unsigned mem_lsb(int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned b_lsb(int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned a_lsb(int unsigned dw);
    return 3 * dw;
  endfunction

  function automatic int unsigned movi_lsb(int unsigned dw);
    return 4 * dw;
  endfunction

  function automatic int unsigned op_lsb(int unsigned dw);
    return 4 * dw + ALU_MOVI_W;
  endfunction

  function automatic int unsigned slice_w(int unsigned dw);
    return ALU_OP_W + ALU_MOVI_W + 4 * dw;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req  - request vector, one bit per port
//   ptr  - highest-priority port index; search runs upward and wraps to 0
//   gnt  - one-hot winner (all zero when no request)
//   idx  - winner index (0 when no request)
//   any  - at least one request present
module alu_rr_arbiter
  import sv_alu_ctrl_pkg::*;
#(
  parameter int unsigned PORTS = 4
) (
  input  logic [PORTS-1:0]      req,
  input  logic [PORT_IDX_W-1:0] ptr,
  output logic [PORTS-1:0]      gnt,
  output logic [PORT_IDX_W-1:0] idx,
  output logic                  any
);

  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      j = (32'(ptr) + i) % PORTS;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PORT_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among PORTS requesters, with a single
// outstanding operation and a result timeout.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_vld/req_rdy     - per-port request handshake (req_rdy at most one-hot)
//   req_data            - per-port {op, movi, a, b, mem, imm}, port i in slice i
//   alu_act/alu_rdy     - operation handshake toward the ALU
//   alu_op..alu_imm     - latched operation fields
//   alu_res/alu_res_vld - ALU result return
//   res_vld/res_data    - one-cycle result strobe to the owning port, held data
//   err/err_port        - one-cycle timeout pulse and offending port
module alu_arbiter
  import sv_alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PORTS      = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [PORTS-1:0]                                  req_vld,
  output logic [PORTS-1:0]                                  req_rdy,
  input  logic [PORTS*(ALU_OP_W+ALU_MOVI_W+4*DATA_WIDTH)-1:0] req_data,
  output logic                                              alu_act,
  output logic [ALU_OP_W-1:0]                               alu_op,
  output logic [ALU_MOVI_W-1:0]                             alu_movi,
  output logic [DATA_WIDTH-1:0]                             alu_reg_a,
  output logic [DATA_WIDTH-1:0]                             alu_reg_b,
  output logic [DATA_WIDTH-1:0]                             alu_mem,
  output logic [DATA_WIDTH-1:0]                             alu_imm,
  input  logic                                              alu_rdy,
  input  logic [DATA_WIDTH-1:0]                             alu_res,
  input  logic                                              alu_res_vld,
  output logic [PORTS-1:0]                                  res_vld,
  output logic [DATA_WIDTH-1:0]                             res_data,
  output logic                                              err,
  output logic [PORT_IDX_W-1:0]                             err_port
);

  localparam int unsigned SLICE_W   = slice_w(DATA_WIDTH);
  localparam int unsigned OP_LSB    = op_lsb(DATA_WIDTH);
  localparam int unsigned MOVI_LSB  = movi_lsb(DATA_WIDTH);
  localparam int unsigned A_LSB     = a_lsb(DATA_WIDTH);
  localparam int unsigned B_LSB     = b_lsb(DATA_WIDTH);
  localparam int unsigned MEM_LSB   = mem_lsb(DATA_WIDTH);
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  state_e                  state;
  logic [PORT_IDX_W-1:0]   ptr;
  logic [PORT_IDX_W-1:0]   gnt;
  logic [PORT_IDX_W-1:0]   ptr_next;
  logic [CNT_W-1:0]        cnt;
  logic [PORTS-1:0]        win_gnt;
  logic [PORT_IDX_W-1:0]   win_idx;
  logic                    win_any;
  logic [SLICE_W-1:0]      win_slice;

  alu_rr_arbiter #(
    .PORTS(PORTS)
  ) u_rr (
    .req(req_vld),
    .ptr(ptr),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );

  // Only offered while idle; held off during reset so no accept is implied.
  assign req_rdy = (state == StIdle && !rst) ? win_gnt : '0;

  assign ptr_next = (gnt == PORT_IDX_W'(PORTS - 1)) ? '0 : gnt + PORT_IDX_W'(1);

  always_comb begin
    win_slice = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (win_idx == PORT_IDX_W'(i)) win_slice = req_data[i*SLICE_W +: SLICE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      alu_act   <= 1'b0;
      alu_op    <= '0;
      alu_movi  <= '0;
      alu_reg_a <= '0;
      alu_reg_b <= '0;
      alu_mem   <= '0;
      alu_imm   <= '0;
      res_vld   <= '0;
      res_data  <= '0;
      err       <= 1'b0;
      err_port  <= '0;
    end else begin
      res_vld <= '0;
      err     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (win_any) begin
            gnt       <= win_idx;
            alu_op    <= win_slice[OP_LSB +: ALU_OP_W];
            alu_movi  <= win_slice[MOVI_LSB +: ALU_MOVI_W];
            alu_reg_a <= win_slice[A_LSB +: DATA_WIDTH];
            alu_reg_b <= win_slice[B_LSB +: DATA_WIDTH];
            alu_mem   <= win_slice[MEM_LSB +: DATA_WIDTH];
            alu_imm   <= win_slice[IMM_LSB +: DATA_WIDTH];
            alu_act   <= 1'b1;
            state     <= StIssue;
          end
        end
        StIssue: begin
          if (alu_rdy) begin
            alu_act <= 1'b0;
            cnt     <= '0;
            state   <= StWait;
          end
        end
        StWait: begin
          // A result arriving on the last allowed cycle beats the timeout.
          if (alu_res_vld) begin
            res_vld  <= PORTS'(1) << gnt;
            res_data <= alu_res;
            ptr      <= ptr_next;
            state    <= StIdle;
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            err_port <= gnt;
            ptr      <= ptr_next;
            state    <= StIdle;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected results/errors go into a
// scoreboard queue and a negedge monitor pops them as the DUT strobes.
module tb_alu_arbiter;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int SW = 6 + 4 * DW;

  typedef struct packed {
    logic       is_err;
    logic [2:0] port;
    logic [7:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      req_vld;
  logic [NP-1:0]      req_rdy;
  logic [NP*SW-1:0]   req_data;
  logic               alu_act;
  logic [3:0]         alu_op;
  logic [1:0]         alu_movi;
  logic [DW-1:0]      alu_reg_a, alu_reg_b, alu_mem, alu_imm;
  logic               alu_rdy;
  logic [DW-1:0]      alu_res;
  logic               alu_res_vld;
  logic [NP-1:0]      res_vld;
  logic [DW-1:0]      res_data;
  logic               err;
  logic [2:0]         err_port;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  exp_t sb[$];

  logic [3:0] op_t[NP];
  logic [1:0] mv_t[NP];
  logic [7:0] a_t[NP], b_t[NP], m_t[NP], i_t[NP], r_t[NP];

  alu_arbiter #(.DATA_WIDTH(DW), .PORTS(NP), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
    .alu_act(alu_act), .alu_op(alu_op), .alu_movi(alu_movi), .alu_reg_a(alu_reg_a),
    .alu_reg_b(alu_reg_b), .alu_mem(alu_mem), .alu_imm(alu_imm), .alu_rdy(alu_rdy),
    .alu_res(alu_res), .alu_res_vld(alu_res_vld), .res_vld(res_vld), .res_data(res_data),
    .err(err), .err_port(err_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_err, input int p, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.port   = 3'(p);
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic chk_issue(input int p);
    chk("act_issue", alu_act, 1'b1);
    chk("rdy_issue", req_rdy, '0);
    chk("resvld_issue", res_vld, '0);
    chk("alu_op", alu_op, op_t[p]);
    chk("alu_movi", alu_movi, mv_t[p]);
    chk("alu_reg_a", alu_reg_a, a_t[p]);
    chk("alu_reg_b", alu_reg_b, b_t[p]);
    chk("alu_mem", alu_mem, m_t[p]);
    chk("alu_imm", alu_imm, i_t[p]);
  endtask

  // Starts at the drive point of an IDLE cycle where port p must win; returns
  // at the drive point of the IDLE cycle carrying its result strobe.
  task automatic op_cycle(input int p, input int stall, input bit noise, input bit hold,
                          input bit exp_err);
    logic [3:0] one;
    one = 4'b0001 << p;
    @(negedge clk);
    chk("grant", req_rdy, one);
    chk("err_at_idle", err, exp_err);
    tick();
    if (!hold) req_vld = '0;
    for (int k = 0; k < stall; k++) begin
      alu_rdy     = 1'b0;
      alu_res_vld = noise;
      alu_res     = 8'hEE;
      @(negedge clk);
      chk_issue(p);
      tick();
    end
    alu_res_vld = 1'b0;
    alu_rdy     = 1'b1;
    @(negedge clk);
    chk_issue(p);
    tick();
    alu_rdy     = 1'b0;
    alu_res_vld = 1'b1;
    alu_res     = r_t[p];
    push_exp(1'b0, p, r_t[p]);
    @(negedge clk);
    chk("act_wait", alu_act, 1'b0);
    chk("rdy_wait", req_rdy, '0);
    tick();
    alu_res_vld = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] one;
    if (mon_en && !rst && (res_vld != '0 || err)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=res_vld:%0h err:%0b expected=none t=%0t",
                 res_vld, err, $time);
      end else begin
        e   = sb.pop_front();
        one = 4'b0001 << e.port;
        if (e.is_err) begin
          chk("sb_err", err, 1'b1);
          chk("sb_err_port", err_port, e.port);
          chk("sb_err_no_res", res_vld, '0);
        end else begin
          chk("sb_res_vld", res_vld, one);
          chk("sb_res_data", res_data, e.data);
          chk("sb_res_no_err", err, 1'b0);
        end
      end
    end
  end

  initial begin
    op_t = '{4'h1, 4'h2, 4'h0, 4'h3};
    mv_t = '{2'd1, 2'd2, 2'd0, 2'd3};
    a_t  = '{8'h10, 8'h20, 8'h05, 8'h40};
    b_t  = '{8'h01, 8'h02, 8'h03, 8'h04};
    m_t  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    i_t  = '{8'h50, 8'h51, 8'h52, 8'h53};
    r_t  = '{8'h11, 8'h22, 8'h08, 8'h44};  // a + b, hand-computed
    for (int p = 0; p < NP; p++)
      req_data[p*SW +: SW] = {op_t[p], mv_t[p], a_t[p], b_t[p], m_t[p], i_t[p]};
    rst = 1'b1; req_vld = '1; alu_rdy = 1'b0; alu_res = '0; alu_res_vld = 1'b0;

    // Reset: no ready while held, then reset values.
    tick(); tick();
    @(negedge clk);
    chk("rdy_in_reset", req_rdy, '0);
    tick();
    rst = 1'b0; req_vld = '0;
    @(negedge clk);
    chk("rst_act", alu_act, 1'b0);
    chk("rst_res_vld", res_vld, '0);
    chk("rst_res_data", res_data, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_port", err_port, '0);
    chk("rst_alu_op", alu_op, '0);
    chk("rst_alu_a", alu_reg_a, '0);
    mon_en = 1'b1;
    tick();

    // Single request, minimum latency: result strobe three cycles after accept.
    req_vld = 4'b0100;
    op_cycle(2, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_res_vld", res_vld, 4'b0100);
    chk("lat_res_data", res_data, 8'h08);
    tick();

    // Fairness from pointer 0 with all ports requesting, back-to-back accepts.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_vld = '1;
    for (int n = 0; n < 8; n++) op_cycle(n % 4, 0, 1'b0, 1'b1, 1'b0);
    req_vld = '0;
    tick();
    @(negedge clk);
    chk("res_data_hold", res_data, 8'h44);
    chk("res_vld_pulse", res_vld, '0);
    tick();

    // Back-pressure with stray results during ISSUE.
    req_vld = 4'b0001;
    op_cycle(0, 5, 1'b1, 1'b0, 1'b0);

    // Timeout on port 1, then next grant goes to port 2.
    req_vld = 4'b0010;
    @(negedge clk);
    chk("to_grant", req_rdy, 4'b0010);
    tick();
    req_vld = '0; alu_rdy = 1'b1;
    @(negedge clk);
    chk("to_act", alu_act, 1'b1);
    tick();
    alu_rdy = 1'b0;
    push_exp(1'b1, 1, 8'h00);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("to_no_err_early", err, 1'b0);
      tick();
    end
    req_vld = 4'b0111;
    op_cycle(2, 0, 1'b0, 1'b0, 1'b1);

    // Result on the final timeout cycle wins.
    req_vld = 4'b1000;
    @(negedge clk);
    chk("col_grant", req_rdy, 4'b1000);
    tick();
    req_vld = '0; alu_rdy = 1'b1;
    tick();
    alu_rdy = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    alu_res_vld = 1'b1; alu_res = 8'h5A;
    push_exp(1'b0, 3, 8'h5A);
    tick();
    alu_res_vld = 1'b0;
    @(negedge clk);
    chk("col_res_vld", res_vld, 4'b1000);
    chk("col_no_err", err, 1'b0);
    tick();
    @(negedge clk);
    chk("col_no_err_late", err, 1'b0);
    tick();

    // Reset during WAIT: the late result is ignored and the pointer returns to 0.
    req_vld = 4'b0001;
    op_cycle(0, 0, 1'b0, 1'b0, 1'b0);
    req_vld = 4'b0100;
    @(negedge clk);
    chk("rw_grant", req_rdy, 4'b0100);
    tick();
    req_vld = '0; alu_rdy = 1'b1;
    tick();
    alu_rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; alu_res_vld = 1'b1; alu_res = 8'h77;
    @(negedge clk);
    chk("rw_res_vld", res_vld, '0);
    chk("rw_err", err, 1'b0);
    chk("rw_act", alu_act, 1'b0);
    chk("rw_res_data", res_data, '0);
    chk("rw_alu_a", alu_reg_a, '0);
    tick();
    alu_res_vld = 1'b0; req_vld = '1;
    @(negedge clk);
    chk("rw_ignored_res", res_vld, '0);
    chk("rw_ptr0", req_rdy, 4'b0001);
    tick();
    req_vld = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ALU operand/result width.
REQ-002 Parameter PORTS, default 4, number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 16, max cycles from issue to ALU result.
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 REQ_VLD  in  PORTS  per-port request valid.
REQ-007 REQ_RDY  out  PORTS  per-port accept, at most one bit high.
REQ-008 REQ_DATA  in  PORTS*(6+4*DATA_WIDTH)  per-port {OP[3:0], MOVI[1:0], A, B, MEM, IMM}; port i occupies slice i.
REQ-009 ALU_ACT  out  1  operation valid toward ALU.
REQ-010 ALU_OP  out  4 ; ALU_MOVI  out  2 ; ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM  out  DATA_WIDTH each  latched operation fields.
REQ-011 ALU_RDY  in  1  ALU accepts operation when ALU_ACT && ALU_RDY.
REQ-012 ALU_RES  in  DATA_WIDTH ; ALU_RES_VLD  in  1  ALU result and its valid.
REQ-013 RES_VLD  out  PORTS  one-hot, one-cycle result strobe to owning port.
REQ-014 RES_DATA  out  DATA_WIDTH  registered result.
REQ-015 ERR  out  1 ; ERR_PORT  out  3  one-cycle timeout pulse and offending port index.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT; exactly one outstanding ALU operation.
REQ-017 IDLE: REQ_RDY combinationally one-hot on round-robin winner among REQ_VLD, searching from pointer PTR upward with wrap PORTS-1 -> 0; all zero if no REQ_VLD or state not IDLE.
REQ-018 On REQ_VLD[g] && REQ_RDY[g]: latch slice g into ALU_* registers, latch GNT=g, go ISSUE next cycle.
REQ-019 ISSUE: ALU_ACT=1, fields stable; remain while ALU_RDY=0; on ALU_RDY=1 go WAIT, clear cycle counter CNT to 0.
REQ-020 WAIT: ALU_ACT=0; CNT increments each cycle, saturating at TIMEOUT.
REQ-021 WAIT with ALU_RES_VLD=1: next cycle RES_VLD[GNT]=1, RES_DATA=ALU_RES; PTR=GNT+1 mod PORTS; go IDLE.
REQ-022 WAIT with CNT==TIMEOUT-1 and no ALU_RES_VLD: next cycle ERR=1, ERR_PORT=GNT, no RES_VLD; PTR=GNT+1 mod PORTS; go IDLE.
REQ-023 ALU_RES_VLD and timeout in same cycle: result wins, no ERR.
REQ-024 ALU_RES_VLD in IDLE or ISSUE ignored, no output effect.
REQ-025 Minimum latency: accept at cycle 0, ALU_ACT cycle 1, earliest RES_VLD cycle 3 (ALU_RDY=1 at cycle 1, result at cycle 2).
REQ-026 Back-to-back: new request may be accepted in the IDLE cycle RES_VLD/ERR is high.
REQ-027 RES_DATA holds last value between strobes.

Reset
REQ-028 RST=1 at a clock edge: state IDLE, PTR=0, GNT=0, CNT=0, all ALU_* fields 0, ALU_ACT=0, RES_VLD=0, RES_DATA=0, ERR=0, ERR_PORT=0.
REQ-029 REQ_RDY=0 while RST=1.
REQ-030 RST mid-operation abandons the operation: no RES_VLD, no ERR for it; a later ALU_RES_VLD is ignored per REQ-024.

Structure
REQ-031 Shared package sv_alu_ctrl_pkg holds state enum, ALU_OP_W=4, ALU_MOVI_W=2, and the request-slice field offsets.
REQ-032 Round-robin winner selection in sub-module alu_rr_arbiter (inputs REQ, PTR; outputs one-hot GNT, index), purely combinational.

Verification
REQ-033 Single request: port 2 REQ_DATA {OP=0 (ADD), A=8'h05, B=8'h03}, ALU_RDY=1, result 8'h08 next cycle -> ALU_ACT at cycle 1, RES_VLD=4'b0100, RES_DATA=8'h08 at cycle 3.
REQ-034 Fairness: all four REQ_VLD held high for 8 operations -> grant order 0,1,2,3,0,1,2,3.
REQ-035 Back-pressure: ALU_RDY low 5 cycles in ISSUE -> ALU_ACT high 6 cycles with ALU_* fields unchanged, REQ_RDY all zero throughout.
REQ-036 Timeout: TIMEOUT=16, port 1 issued, no ALU_RES_VLD -> ERR=1, ERR_PORT=1 exactly 16 cycles after leaving ISSUE; next grant goes to port 2.
REQ-037 Collision: ALU_RES_VLD on final timeout cycle -> RES_VLD asserted, ERR stays 0.
REQ-038 Reset in WAIT, then ALU_RES_VLD=1 -> no RES_VLD, no ERR, all outputs at reset values, PTR=0.
